// File: rtl/game_sequencer_pkg.sv
// Shared game-flow constants and state encodings, so display and VGA logic can decode game_state.
// Optional feature macro used by game_sequencer: GAME_SEQ_EXTRA_LIFE_EN.
package game_sequencer_pkg;

    localparam logic [2:0] ST_ATTRACT = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_PLAYING = 3'd2;
    localparam logic [2:0] ST_HIT     = 3'd3;
    localparam logic [2:0] ST_CLEAR   = 3'd4;
    localparam logic [2:0] ST_OVER    = 3'd5;

    localparam int LIVES_INIT     = 3;
    localparam int RESPAWN_FRAMES = 120;
    localparam int CLEAR_FRAMES   = 90;
    localparam int OVER_FRAMES    = 180;
    localparam int INVADE_Y       = 440;
    localparam int WAVE_MAX       = 15;

    // Frame counter width; every frame delay above must fit in it.
    localparam int FCNT_W = 8;

    function automatic logic [3:0] wave_advance(input logic [3:0] wave, input logic [3:0] wave_max);
        return (wave >= wave_max) ? wave_max : wave + 4'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame-pulse counter with clear, saturating at a selectable limit and flagging when it is there.
module game_sequencer_frame_timer
    import game_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              frame,
    input  logic [FCNT_W-1:0] limit,
    output logic              done
);

    logic [FCNT_W-1:0] fcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
        end else if (clear) begin
            fcnt <= '0;
        end else if (frame && (fcnt < limit)) begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign done = (fcnt == limit);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: attract, play, hit-respawn, wave-clear and game-over sequencing.
// Define GAME_SEQ_EXTRA_LIFE_EN to award a life (capped at 3) on every cleared wave.
module game_sequencer #(
    parameter int LIVES_INIT     = game_sequencer_pkg::LIVES_INIT,
    parameter int RESPAWN_FRAMES = game_sequencer_pkg::RESPAWN_FRAMES,
    parameter int CLEAR_FRAMES   = game_sequencer_pkg::CLEAR_FRAMES,
    parameter int OVER_FRAMES    = game_sequencer_pkg::OVER_FRAMES,
    parameter int INVADE_Y       = game_sequencer_pkg::INVADE_Y,
    parameter int WAVE_MAX       = game_sequencer_pkg::WAVE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arst,
    input  logic        frame,
    input  logic        shoot,
    input  logic [1:0]  player_collision,
    input  logic [54:0] invaders,
    input  logic [9:0]  invaders_y,
    output logic        run_en,
    output logic        wave_load,
    output logic        player_load,
    output logic [1:0]  lives,
    output logic [3:0]  wave,
    output logic [2:0]  game_state
);
    import game_sequencer_pkg::*;

    localparam logic [1:0]        LIVES_INIT_C = 2'(LIVES_INIT);
    localparam logic [FCNT_W-1:0] RESPAWN_LAST = FCNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [FCNT_W-1:0] CLEAR_LAST   = FCNT_W'(CLEAR_FRAMES - 1);
    localparam logic [FCNT_W-1:0] OVER_LIMIT   = FCNT_W'(OVER_FRAMES);
    localparam logic [9:0]        INVADE_Y_C   = 10'(INVADE_Y);
    localparam logic [3:0]        WAVE_MAX_C   = 4'(WAVE_MAX);

    logic [2:0]        state, state_nx;
    logic [1:0]        lives_nx;
    logic [3:0]        wave_nx;
    logic              wave_load_nx, player_load_nx;
    logic              fcnt_clear, fcnt_done;
    logic [FCNT_W-1:0] fcnt_limit;

    game_sequencer_frame_timer u_frame_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (fcnt_clear | arst),
        .frame (frame),
        .limit (fcnt_limit),
        .done  (fcnt_done)
    );

    // PLAYING holds the timer at zero, so every timed phase starts counting from a clean frame count.
    always_comb begin
        state_nx       = state;
        lives_nx       = lives;
        wave_nx        = wave;
        wave_load_nx   = 1'b0;
        player_load_nx = 1'b0;
        fcnt_clear     = 1'b0;
        fcnt_limit     = OVER_LIMIT;
        case (state)
            ST_ATTRACT: begin
                fcnt_clear = 1'b1;
                if (shoot) state_nx = ST_START;
            end
            ST_START: begin
                lives_nx       = LIVES_INIT_C;
                wave_nx        = 4'd1;
                wave_load_nx   = 1'b1;
                player_load_nx = 1'b1;
                fcnt_clear     = 1'b1;
                state_nx       = ST_PLAYING;
            end
            ST_PLAYING: begin
                fcnt_clear = 1'b1;
                if (invaders_y >= INVADE_Y_C) begin
                    lives_nx = 2'd0;
                    state_nx = ST_OVER;
                end else if (player_collision != 2'b00) begin
                    if (lives == 2'd1) begin
                        lives_nx = 2'd0;
                        state_nx = ST_OVER;
                    end else begin
                        lives_nx = lives - 2'd1;
                        state_nx = ST_HIT;
                    end
                end else if (invaders == '0) begin
                    state_nx = ST_CLEAR;
                end
            end
            ST_HIT: begin
                fcnt_limit = RESPAWN_LAST;
                if (frame && fcnt_done) begin
                    player_load_nx = 1'b1;
                    fcnt_clear     = 1'b1;
                    state_nx       = ST_PLAYING;
                end
            end
            ST_CLEAR: begin
                fcnt_limit = CLEAR_LAST;
                if (frame && fcnt_done) begin
                    wave_nx        = wave_advance(wave, WAVE_MAX_C);
`ifdef GAME_SEQ_EXTRA_LIFE_EN
                    lives_nx       = (lives == 2'd3) ? 2'd3 : lives + 2'd1;
`endif
                    wave_load_nx   = 1'b1;
                    player_load_nx = 1'b1;
                    fcnt_clear     = 1'b1;
                    state_nx       = ST_PLAYING;
                end
            end
            ST_OVER: begin
                if (shoot && fcnt_done) begin
                    fcnt_clear = 1'b1;
                    state_nx   = ST_START;
                end
            end
            default: begin
                fcnt_clear = 1'b1;
                state_nx   = ST_ATTRACT;
            end
        endcase
    end

    // run_en and game_state trail the internal state by one clock; loads are registered decisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_ATTRACT;
            lives       <= 2'd0;
            wave        <= 4'd0;
            run_en      <= 1'b0;
            wave_load   <= 1'b0;
            player_load <= 1'b0;
            game_state  <= ST_ATTRACT;
        end else if (arst) begin
            state       <= ST_ATTRACT;
            lives       <= 2'd0;
            wave        <= 4'd0;
            run_en      <= 1'b0;
            wave_load   <= 1'b0;
            player_load <= 1'b0;
            game_state  <= ST_ATTRACT;
        end else begin
            state       <= state_nx;
            lives       <= lives_nx;
            wave        <= wave_nx;
            run_en      <= (state == ST_PLAYING);
            wave_load   <= wave_load_nx;
            player_load <= player_load_nx;
            game_state  <= state;
        end
    end

    // Losing a life is only reachable from PLAYING, which always holds at least one life.
    assert property (@(posedge clk) disable iff (!rst) !((state == ST_PLAYING) && (lives == 2'd0)));

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer against a phase/countdown reference model.
// Honours GAME_SEQ_EXTRA_LIFE_EN in the model when the design is built with it.
module tb_game_sequencer;

    localparam int LIVES_INIT     = 3;
    localparam int RESPAWN_FRAMES = 120;
    localparam int CLEAR_FRAMES   = 90;
    localparam int OVER_FRAMES    = 180;
    localparam int INVADE_Y       = 440;
    localparam int WAVE_MAX       = 15;
    localparam int NUM_CYCLES     = 20000;

    localparam int P_ATTRACT = 0;
    localparam int P_START   = 1;
    localparam int P_PLAY    = 2;
    localparam int P_HIT     = 3;
    localparam int P_CLEAR   = 4;
    localparam int P_OVER    = 5;

    typedef struct packed {
        logic [2:0] gs;
        logic       run;
        logic [1:0] lives;
        logic [3:0] wave;
        logic       wl;
        logic       pl;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arst = 1'b0;
    logic        frame = 1'b0;
    logic        shoot = 1'b0;
    logic [1:0]  player_collision = 2'b00;
    logic [54:0] invaders = '1;
    logic [9:0]  invaders_y = '0;
    logic        run_en, wave_load, player_load;
    logic [1:0]  lives;
    logic [3:0]  wave;
    logic [2:0]  game_state;

    game_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .arst             (arst),
        .frame            (frame),
        .shoot            (shoot),
        .player_collision (player_collision),
        .invaders         (invaders),
        .invaders_y       (invaders_y),
        .run_en           (run_en),
        .wave_load        (wave_load),
        .player_load      (player_load),
        .lives            (lives),
        .wave             (wave),
        .game_state       (game_state)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: current phase, frames remaining in a timed phase, lives and wave.
    int m_phase = P_ATTRACT;
    int m_left  = 0;
    int m_lives = 0;
    int m_wave  = 0;

    task automatic model_step(output obs_t e);
        int gs_now;
        bit run_now;
        bit wl;
        bit pl;
        gs_now  = m_phase;
        run_now = (m_phase == P_PLAY);
        wl      = 1'b0;
        pl      = 1'b0;
        if (arst) begin
            m_phase = P_ATTRACT;
            m_lives = 0;
            m_wave  = 0;
            m_left  = 0;
            gs_now  = P_ATTRACT;
            run_now = 1'b0;
        end else begin
            case (m_phase)
                P_ATTRACT: if (shoot) m_phase = P_START;
                P_START: begin
                    m_lives = LIVES_INIT;
                    m_wave  = 1;
                    wl      = 1'b1;
                    pl      = 1'b1;
                    m_phase = P_PLAY;
                end
                P_PLAY: begin
                    if (int'(invaders_y) >= INVADE_Y) begin
                        m_lives = 0;
                        m_phase = P_OVER;
                        m_left  = OVER_FRAMES;
                    end else if (player_collision != 2'b00) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin
                            m_phase = P_OVER;
                            m_left  = OVER_FRAMES;
                        end else begin
                            m_phase = P_HIT;
                            m_left  = RESPAWN_FRAMES;
                        end
                    end else if (invaders == '0) begin
                        m_phase = P_CLEAR;
                        m_left  = CLEAR_FRAMES;
                    end
                end
                P_HIT: if (frame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        pl      = 1'b1;
                        m_phase = P_PLAY;
                    end
                end
                P_CLEAR: if (frame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_wave = (m_wave < WAVE_MAX) ? m_wave + 1 : WAVE_MAX;
`ifdef GAME_SEQ_EXTRA_LIFE_EN
                        m_lives = (m_lives < 3) ? m_lives + 1 : 3;
`endif
                        wl      = 1'b1;
                        pl      = 1'b1;
                        m_phase = P_PLAY;
                    end
                end
                P_OVER: begin
                    if (shoot && m_left == 0) m_phase = P_START;
                    else if (frame && m_left > 0) m_left = m_left - 1;
                end
                default: m_phase = P_ATTRACT;
            endcase
        end
        e.gs    = 3'(gs_now);
        e.run   = run_now;
        e.lives = 2'(m_lives);
        e.wave  = 4'(m_wave);
        e.wl    = wl;
        e.pl    = pl;
    endtask

    // A middle window suppresses hits, invasions and soft resets so waves (and lives) reach saturation.
    task automatic apply_stimulus(input int cyc);
        bit calm;
        int r;
        calm  = (cyc >= 8000) && (cyc < 14000);
        frame = ($urandom_range(0, 1) == 1);
        shoot = (cyc >= 40) && ($urandom_range(0, 7) == 0);
        arst  = (cyc >= 40) && !calm && ($urandom_range(0, 1999) == 0);
        player_collision = (!calm && $urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        invaders = ($urandom_range(0, calm ? 3 : 39) == 0) ? '0 : {23'($urandom), $urandom};
        r = $urandom_range(0, 299);
        if (!calm && r == 0)  invaders_y = 10'($urandom_range(INVADE_Y, 1023));
        else if (r == 1)      invaders_y = 10'(INVADE_Y - 1);
        else                  invaders_y = 10'($urandom_range(0, INVADE_Y - 2));
        if (!calm && m_phase == P_PLAY && m_lives == 1 && $urandom_range(0, 3) == 0) begin
            invaders         = '0;
            player_collision = 2'b01;
        end
    endtask

    task automatic check_output(input obs_t e);
        obs_t a;
        a = {game_state, run_en, lives, wave, wave_load, player_load};
        checks++;
        if (a === e) begin
            passes++;
        end else begin
            $display("[TB] FAIL outputs t=%0t got gs=%0d run=%0b lives=%0d wave=%0d wl=%0b pl=%0b expected gs=%0d run=%0b lives=%0d wave=%0d wl=%0b pl=%0b",
                     $time, a.gs, a.run, a.lives, a.wave, a.wl, a.pl,
                     e.gs, e.run, e.lives, e.wave, e.wl, e.pl);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check_output(exp_q.pop_front());
        end
    end

    initial begin : stimulus
        obs_t e;
        repeat (4) begin
            @(negedge clk);
            exp_q.push_back('0);
        end
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            rst = 1'b1;
            apply_stimulus(cyc);
            model_step(e);
            exp_q.push_back(e);
        end
        @(negedge clk);
        shoot = 1'b0;
        arst  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
